// File: rtl/sqrt_disp_pkg.sv
// Shared types and seven-segment constants for the sqrt result display.
// Segment ordering is {g,f,e,d,c,b,a}, active-high.
package sqrt_disp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   localparam int BCD_DIGITS = 3;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_r     = 7'h50;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit-to-segment encoder with blank and "Err" overrides.
// In error mode a digit code of 4'hE renders 'E', anything else renders 'r'.
module seg7_encode
   import sqrt_disp_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       err,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (blank) begin
         seg = SEG_BLANK;
      end else if (err) begin
         seg = (digit == 4'hE) ? SEG_E : SEG_r;
      end else if (digit <= 4'd9) begin
         seg = SEG_DIGIT[digit];
      end
   end

endmodule

// File: rtl/sqrt_result_display.sv
// Captures a sqrt result, converts it to BCD by sequential double-dabble,
// and scans it onto a 4-digit multiplexed seven-segment display.
module sqrt_result_display
   import sqrt_disp_pkg::*;
#(
   parameter int SCAN_DIV = 4,
   parameter int WIDTH    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             done_in,
   input  logic             invalid_in,
   input  logic [WIDTH-1:0] answer_in,
   output logic             busy,
   output logic             result_valid,
   output logic             err_flag,
   output logic             overrun,
   output logic [3:0]       bcd_hundreds,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones,
   output logic [6:0]       seg,
   output logic [3:0]       an
);

   localparam int SR_W  = 4 * BCD_DIGITS + WIDTH;
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   state_t            state;
   logic [SR_W-1:0]   shreg;
   logic [SR_W-1:0]   shreg_next;
   logic [CNT_W-1:0]  iter;
   logic [PRE_W-1:0]  presc;

   logic [3:0]        digit;
   logic              digit_blank;
   logic              blank_all;

   // One shift-add-3 iteration over the BCD nibbles sitting above the binary field.
   function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
      logic [SR_W-1:0] r;
      r = s;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (r[WIDTH + 4*i +: 4] >= 4'd5)
            r[WIDTH + 4*i +: 4] = r[WIDTH + 4*i +: 4] + 4'd3;
      end
      return {r[SR_W-2:0], 1'b0};
   endfunction

   assign shreg_next = dabble_step(shreg);
   assign busy       = (state == CONVERT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         shreg        <= '0;
         iter         <= '0;
         result_valid <= 1'b0;
         err_flag     <= 1'b0;
         overrun      <= 1'b0;
         bcd_hundreds <= 4'd0;
         bcd_tens     <= 4'd0;
         bcd_ones     <= 4'd0;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (done_in) begin
                  overrun <= 1'b0;
                  if (invalid_in) begin
                     state        <= HOLD;
                     err_flag     <= 1'b1;
                     result_valid <= 1'b1;
                     bcd_hundreds <= 4'd0;
                     bcd_tens     <= 4'd0;
                     bcd_ones     <= 4'd0;
                  end else begin
                     state        <= CONVERT;
                     shreg        <= {{(4*BCD_DIGITS){1'b0}}, answer_in};
                     iter         <= '0;
                     result_valid <= 1'b0;
                     err_flag     <= 1'b0;
                  end
               end
            end
            CONVERT: begin
               // A result arriving mid-conversion is dropped but remembered as an overrun.
               shreg <= shreg_next;
               iter  <= iter + CNT_W'(1);
               if (done_in)
                  overrun <= 1'b1;
               if (iter == CNT_W'(WIDTH - 1)) begin
                  state        <= HOLD;
                  result_valid <= 1'b1;
                  bcd_hundreds <= shreg_next[SR_W-1  -: 4];
                  bcd_tens     <= shreg_next[SR_W-5  -: 4];
                  bcd_ones     <= shreg_next[SR_W-9  -: 4];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc <= '0;
         an    <= 4'b0001;
      end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
         presc <= '0;
         an    <= {an[2:0], an[3]};
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

   assign blank_all = busy || !result_valid;

   // Leading-zero suppression applies to numeric results only, never to "Err".
   always_comb begin
      digit       = 4'd0;
      digit_blank = 1'b1;
      case (an)
         4'b0001: begin
            digit       = err_flag ? 4'd0 : bcd_ones;
            digit_blank = blank_all;
         end
         4'b0010: begin
            digit       = err_flag ? 4'd0 : bcd_tens;
            digit_blank = blank_all ||
                          (!err_flag && bcd_hundreds == 4'd0 && bcd_tens == 4'd0);
         end
         4'b0100: begin
            digit       = err_flag ? 4'hE : bcd_hundreds;
            digit_blank = blank_all || (!err_flag && bcd_hundreds == 4'd0);
         end
         default: begin
            digit       = 4'd0;
            digit_blank = 1'b1;
         end
      endcase
   end

   seg7_encode u_encode (
      .digit (digit),
      .blank (digit_blank),
      .err   (err_flag),
      .seg   (seg)
   );

endmodule
